id_exe_stage_reg: RTL and testbench

- ID/EXE pipeline register of the 5-stage ARM core.
- Captures decoded control, operand values, shift_operand/immediate fields and the status-register flags at the end of ID.
- Presents them registered to the EXE stage, i.e. to the Val2 generator, ALU and branch-target adder.
- Supports freeze (hold, for memory stall) and flush (bubble insertion, for branch taken), and tracks a per-slot valid bit.

---
 rtl/id_exe_stage_reg.sv | 167 ++++++++++++++++
 tb/tb_id_exe_stage_reg.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_exe_stage_reg.sv
// ---------------------------------------------------------------------------
// id_exe_stage_reg
//
// ID/EXE pipeline register of the 5-stage ARM core. Captures the decoded
// controls, operand values, shift_operand / immediate fields and the status
// flags at the end of ID and presents them, registered, to the EXE stage
// (Val2 generator, ALU, branch-target adder).
//
// Per rising edge the priority is rst > flush > freeze > load:
//   rst    : every output cleared to zero
//   flush  : a full-zero bubble is captured (even while frozen)
//   freeze : every output holds its previous value
//   load   : every field takes its input
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   flush, freeze         bubble insertion / hold
//   valid_in/valid_out    slot valid bit
//   pc_in/pc_out          PC+4 of the instruction
//   wb_en, mem_r_en, mem_w_en, b, s (_in/_out)  decoded controls
//   exe_cmd_in/_out       ALU command
//   val_rn, val_rm        register operand values
//   immediate             I bit
//   shift_operand         instruction[11:0], passed through
//   signed_imm_24         branch offset, passed through (no sign extension)
//   dest, src1, src2      register numbers
//   sr_in                 status flags {N,Z,C,V}
//   carry_out             captured C flag for ADC/SBC
//   is_mem_instruction_out  registered (mem_r_en_in | mem_w_en_in)
// ---------------------------------------------------------------------------
module id_exe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int CMD_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              freeze,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic              b_in,
    input  logic              s_in,
    input  logic [CMD_W-1:0]  exe_cmd_in,
    input  logic [DATA_W-1:0] val_rn_in,
    input  logic [DATA_W-1:0] val_rm_in,
    input  logic              immediate_in,
    input  logic [11:0]       shift_operand_in,
    input  logic [23:0]       signed_imm_24_in,
    input  logic [REG_AW-1:0] dest_in,
    input  logic [REG_AW-1:0] src1_in,
    input  logic [REG_AW-1:0] src2_in,
    input  logic [3:0]        sr_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] pc_out,
    output logic              wb_en_out,
    output logic              mem_r_en_out,
    output logic              mem_w_en_out,
    output logic              b_out,
    output logic              s_out,
    output logic [CMD_W-1:0]  exe_cmd_out,
    output logic [DATA_W-1:0] val_rn_out,
    output logic [DATA_W-1:0] val_rm_out,
    output logic              immediate_out,
    output logic [11:0]       shift_operand_out,
    output logic [23:0]       signed_imm_24_out,
    output logic [REG_AW-1:0] dest_out,
    output logic [REG_AW-1:0] src1_out,
    output logic [REG_AW-1:0] src2_out,
    output logic              carry_out,
    output logic              is_mem_instruction_out
);

    // One pipeline slot; an all-zero slot is the bubble.
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic              wb_en;
        logic              mem_r_en;
        logic              mem_w_en;
        logic              b;
        logic              s;
        logic [CMD_W-1:0]  exe_cmd;
        logic [DATA_W-1:0] val_rn;
        logic [DATA_W-1:0] val_rm;
        logic              immediate;
        logic [11:0]       shift_operand;
        logic [23:0]       signed_imm_24;
        logic [REG_AW-1:0] dest;
        logic [REG_AW-1:0] src1;
        logic [REG_AW-1:0] src2;
        logic              carry;
        logic              is_mem;
    } slot_t;

    slot_t slot_in;
    slot_t slot_d;
    slot_t slot_q;

    // Controls are taken as presented, even when valid_in is low; zeroing
    // them for non-instructions is the hazard unit's job.
    always_comb begin
        slot_in               = '0;
        slot_in.valid         = valid_in;
        slot_in.pc            = pc_in;
        slot_in.wb_en         = wb_en_in;
        slot_in.mem_r_en      = mem_r_en_in;
        slot_in.mem_w_en      = mem_w_en_in;
        slot_in.b             = b_in;
        slot_in.s             = s_in;
        slot_in.exe_cmd       = exe_cmd_in;
        slot_in.val_rn        = val_rn_in;
        slot_in.val_rm        = val_rm_in;
        slot_in.immediate     = immediate_in;
        slot_in.shift_operand = shift_operand_in;
        slot_in.signed_imm_24 = signed_imm_24_in;
        slot_in.dest          = dest_in;
        slot_in.src1          = src1_in;
        slot_in.src2          = src2_in;
        slot_in.carry         = sr_in[1];
        slot_in.is_mem        = mem_r_en_in | mem_w_en_in;
    end

    // Flush beats freeze so a taken branch can squash the slot behind a
    // stalled memory access. Data fields are zeroed too, so a bubble never
    // looks like a write to r0 to the forwarding/hazard logic.
    always_comb begin
        slot_d = slot_q;
        if (flush) begin
            slot_d = '0;
        end else if (!freeze) begin
            slot_d = slot_in;
        end
    end

    // ID -> EXE boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign valid_out              = slot_q.valid;
    assign pc_out                 = slot_q.pc;
    assign wb_en_out              = slot_q.wb_en;
    assign mem_r_en_out           = slot_q.mem_r_en;
    assign mem_w_en_out           = slot_q.mem_w_en;
    assign b_out                  = slot_q.b;
    assign s_out                  = slot_q.s;
    assign exe_cmd_out            = slot_q.exe_cmd;
    assign val_rn_out             = slot_q.val_rn;
    assign val_rm_out             = slot_q.val_rm;
    assign immediate_out          = slot_q.immediate;
    assign shift_operand_out      = slot_q.shift_operand;
    assign signed_imm_24_out      = slot_q.signed_imm_24;
    assign dest_out               = slot_q.dest;
    assign src1_out               = slot_q.src1;
    assign src2_out               = slot_q.src2;
    assign carry_out              = slot_q.carry;
    assign is_mem_instruction_out = slot_q.is_mem;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_id_exe_stage_reg
//
// Directed scenarios followed by randomized control/data traffic, all
// checked against a behavioural model of the ID/EXE slot.
// ---------------------------------------------------------------------------
module tb_id_exe_stage_reg;

    logic        clk = 1'b0;
    logic        rst, flush, freeze, valid_in;
    logic [31:0] pc_in;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in;
    logic [3:0]  exe_cmd_in;
    logic [31:0] val_rn_in, val_rm_in;
    logic        immediate_in;
    logic [11:0] shift_operand_in;
    logic [23:0] signed_imm_24_in;
    logic [3:0]  dest_in, src1_in, src2_in;
    logic [3:0]  sr_in;

    logic        valid_out;
    logic [31:0] pc_out;
    logic        wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out;
    logic [3:0]  exe_cmd_out;
    logic [31:0] val_rn_out, val_rm_out;
    logic        immediate_out;
    logic [11:0] shift_operand_out;
    logic [23:0] signed_imm_24_out;
    logic [3:0]  dest_out, src1_out, src2_out;
    logic        carry_out, is_mem_instruction_out;

    always #5 clk = ~clk;

    id_exe_stage_reg #(.DATA_W(32), .REG_AW(4), .CMD_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
        .valid_in(valid_in), .pc_in(pc_in),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .b_in(b_in), .s_in(s_in), .exe_cmd_in(exe_cmd_in),
        .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
        .immediate_in(immediate_in), .shift_operand_in(shift_operand_in),
        .signed_imm_24_in(signed_imm_24_in),
        .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .sr_in(sr_in),
        .valid_out(valid_out), .pc_out(pc_out),
        .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
        .b_out(b_out), .s_out(s_out), .exe_cmd_out(exe_cmd_out),
        .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
        .immediate_out(immediate_out), .shift_operand_out(shift_operand_out),
        .signed_imm_24_out(signed_imm_24_out),
        .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out),
        .carry_out(carry_out), .is_mem_instruction_out(is_mem_instruction_out)
    );

    // Reference model: what EXE should see, as independent variables.
    logic        m_valid, m_wb, m_mr, m_mw, m_b, m_s, m_imm, m_carry, m_ismem;
    logic [31:0] m_pc, m_rn, m_rm;
    logic [3:0]  m_cmd, m_dest, m_src1, m_src2;
    logic [11:0] m_shop;
    logic [23:0] m_simm;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_clear();
        {m_valid, m_wb, m_mr, m_mw, m_b, m_s, m_imm, m_carry, m_ismem} = '0;
        m_pc = '0; m_rn = '0; m_rm = '0;
        m_cmd = '0; m_dest = '0; m_src1 = '0; m_src2 = '0;
        m_shop = '0; m_simm = '0;
    endtask

    // Spec rules: rst clears, flush bubbles, freeze holds, else capture.
    task automatic model_edge();
        if (rst || flush) begin
            model_clear();
        end else if (!freeze) begin
            m_valid = valid_in;   m_pc = pc_in;
            m_wb = wb_en_in;      m_mr = mem_r_en_in;  m_mw = mem_w_en_in;
            m_b = b_in;           m_s = s_in;          m_cmd = exe_cmd_in;
            m_rn = val_rn_in;     m_rm = val_rm_in;    m_imm = immediate_in;
            m_shop = shift_operand_in;                 m_simm = signed_imm_24_in;
            m_dest = dest_in;     m_src1 = src1_in;    m_src2 = src2_in;
            m_carry = sr_in[1];
            m_ismem = mem_r_en_in | mem_w_en_in;
        end
    endtask

    task automatic check_all();
        chk("valid",  64'(valid_out),              64'(m_valid));
        chk("pc",     64'(pc_out),                 64'(m_pc));
        chk("wb_en",  64'(wb_en_out),              64'(m_wb));
        chk("mem_r",  64'(mem_r_en_out),           64'(m_mr));
        chk("mem_w",  64'(mem_w_en_out),           64'(m_mw));
        chk("b",      64'(b_out),                  64'(m_b));
        chk("s",      64'(s_out),                  64'(m_s));
        chk("cmd",    64'(exe_cmd_out),            64'(m_cmd));
        chk("val_rn", 64'(val_rn_out),             64'(m_rn));
        chk("val_rm", 64'(val_rm_out),             64'(m_rm));
        chk("imm",    64'(immediate_out),          64'(m_imm));
        chk("shop",   64'(shift_operand_out),      64'(m_shop));
        chk("simm24", 64'(signed_imm_24_out),      64'(m_simm));
        chk("dest",   64'(dest_out),               64'(m_dest));
        chk("src1",   64'(src1_out),               64'(m_src1));
        chk("src2",   64'(src2_out),               64'(m_src2));
        chk("carry",  64'(carry_out),              64'(m_carry));
        chk("is_mem", 64'(is_mem_instruction_out), 64'(m_ismem));
    endtask

    // Inputs are driven after the falling edge; one call = one rising edge,
    // then outputs are checked at the next falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive_all(input logic v);
        valid_in = v; pc_in = {32{v}};
        wb_en_in = v; mem_r_en_in = v; mem_w_en_in = v; b_in = v; s_in = v;
        exe_cmd_in = {4{v}}; val_rn_in = {32{v}}; val_rm_in = {32{v}};
        immediate_in = v; shift_operand_in = {12{v}}; signed_imm_24_in = {24{v}};
        dest_in = {4{v}}; src1_in = {4{v}}; src2_in = {4{v}}; sr_in = {4{v}};
    endtask

    task automatic drive_rand();
        valid_in = 1'($urandom); pc_in = $urandom;
        wb_en_in = 1'($urandom); mem_r_en_in = 1'($urandom); mem_w_en_in = 1'($urandom);
        b_in = 1'($urandom); s_in = 1'($urandom); exe_cmd_in = 4'($urandom);
        val_rn_in = $urandom; val_rm_in = $urandom; immediate_in = 1'($urandom);
        shift_operand_in = 12'($urandom); signed_imm_24_in = 24'($urandom);
        dest_in = 4'($urandom); src1_in = 4'($urandom); src2_in = 4'($urandom);
        sr_in = 4'($urandom);
    endtask

    initial begin
        model_clear();
        rst = 1'b1; flush = 1'b0; freeze = 1'b0;
        drive_all(1'b1);
        @(negedge clk);

        // Reset with every input high, held for two edges.
        step(); step();
        chk("rst_valid", 64'(valid_out), 64'd0);
        chk("rst_carry", 64'(carry_out), 64'd0);

        // Plain load.
        rst = 1'b0;
        drive_all(1'b0);
        pc_in = 32'h0000_0010; exe_cmd_in = 4'b0010; val_rm_in = 32'h8000_0001;
        shift_operand_in = 12'h0E3; immediate_in = 1'b1; sr_in = 4'b0010; valid_in = 1'b1;
        step();
        chk("ld_pc",    64'(pc_out),            64'h10);
        chk("ld_shop",  64'(shift_operand_out), 64'h0E3);
        chk("ld_carry", 64'(carry_out),         64'd1);
        chk("ld_valid", 64'(valid_out),         64'd1);

        // Memory op.
        mem_r_en_in = 1'b1; mem_w_en_in = 1'b0; shift_operand_in = 12'hFFC;
        step();
        chk("mem_is_mem", 64'(is_mem_instruction_out), 64'd1);
        chk("mem_shop",   64'(shift_operand_out),      64'hFFC);

        // Freeze holds dest=5 for three edges, then 9 appears.
        dest_in = 4'd5;
        step();
        freeze = 1'b1; dest_in = 4'd9;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frz_dest", 64'(dest_out), 64'd5);
        end
        freeze = 1'b0;
        step();
        chk("unfrz_dest", 64'(dest_out), 64'd9);

        // Flush wins over freeze.
        flush = 1'b1; freeze = 1'b1; wb_en_in = 1'b1; mem_w_en_in = 1'b1;
        step();
        chk("fl_valid", 64'(valid_out),    64'd0);
        chk("fl_wb",    64'(wb_en_out),    64'd0);
        chk("fl_mw",    64'(mem_w_en_out), 64'd0);
        chk("fl_dest",  64'(dest_out),     64'd0);
        // Second consecutive flush, then release back to load.
        freeze = 1'b0;
        step();
        flush = 1'b0;
        step();
        chk("rel_wb", 64'(wb_en_out), 64'd1);

        // Reset while frozen.
        pc_in = 32'h20;
        step();
        freeze = 1'b1; pc_in = 32'h44;
        step();
        chk("frz_pc", 64'(pc_out), 64'h20);
        rst = 1'b1;
        step();
        chk("rstfrz_pc", 64'(pc_out), 64'd0);
        rst = 1'b0; freeze = 1'b0;

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            drive_rand();
            rst    = ($urandom_range(0, 29) == 0);
            flush  = ($urandom_range(0, 7) == 0);
            freeze = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
